// File: rtl/mem16_pkg.sv
// mem16_pkg: shared state/lane types and default timing constants for the mem16 word port.
package mem16_pkg;
    typedef enum logic [2:0] {STARTUP, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
    typedef enum logic {LANE_LO, LANE_HI} lane_t;
    localparam int DEF_STARTUP_CYCLES = 2;
    localparam int DEF_TIMEOUT_CYCLES = 15;
endpackage

// File: rtl/mem16_byte_port.sv
// mem16_byte_port: one byte handshake (ISSUE -> WAIT_BUSY -> WAIT_DONE) with a per-byte timeout.
// Ports: aclk/aresetn clock and async active-low reset; start_i launches a byte access;
// mem_ready_i memory ready; strobe_o one-cycle memory strobe; done_o byte finished this cycle;
// abort_o byte timed out this cycle.
module mem16_byte_port
    import mem16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic start_i,
    input  logic mem_ready_i,
    output logic strobe_o,
    output logic done_o,
    output logic abort_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    state_t phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic waiting, advance;
    always_comb begin
        waiting  = phase_q == WAIT_BUSY || phase_q == WAIT_DONE;
        strobe_o = phase_q == ISSUE;
        done_o   = phase_q == WAIT_DONE && mem_ready_i;
        advance  = done_o || (phase_q == WAIT_BUSY && !mem_ready_i);
        // the count spans both wait states so the limit applies to the whole byte
        abort_o  = waiting && !advance && cnt_q == LAST;
        cnt_d    = waiting ? cnt_q + 1'b1 : '0;
        phase_d  = phase_q;
        if (done_o || abort_o) phase_d = IDLE;
        else if (phase_q == ISSUE) phase_d = WAIT_BUSY;
        else if (phase_q == WAIT_BUSY && !mem_ready_i) phase_d = WAIT_DONE;
        // a new start may coincide with done so the high byte follows back to back
        if (start_i) phase_d = ISSUE;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/mem16_word_port.sv
// mem16_word_port: 8/16-bit little-endian request/response port onto an 8-bit strobed memory.
// Ports: aclk/aresetn clock and async active-low reset; rx_req_* / tx_req_ready request channel;
// tx_resp_* / rx_resp_ready response channel; tx_mem_* / rx_mem_* downstream byte memory.
module mem16_word_port
    import mem16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        rx_req_valid,
    output logic        tx_req_ready,
    input  logic        rx_req_write,
    input  logic        rx_req_word,
    input  logic [15:0] rx_req_addr,
    input  logic [15:0] rx_req_wdata,
    output logic        tx_resp_valid,
    input  logic        rx_resp_ready,
    output logic [15:0] tx_resp_rdata,
    output logic        tx_resp_error,
    output logic        tx_mem_enable,
    output logic        tx_mem_write,
    output logic        tx_mem_strobe,
    output logic [15:0] tx_mem_addr,
    output logic [7:0]  tx_mem_data,
    input  logic [7:0]  rx_mem_data,
    input  logic        rx_mem_ready
);
    localparam int SW = $clog2(STARTUP_CYCLES + 1) + 1;
    localparam logic [SW-1:0] BOOT_LAST = SW'(STARTUP_CYCLES - 1);
    // ISSUE here means "byte engine running"; the engine tracks the finer wait phases
    state_t state_q, state_d;
    lane_t lane_q;
    logic [SW-1:0] boot_cnt_q;
    logic [15:0] addr_q, wdata_q, rdata_q;
    logic write_q, word_q, error_q, enable_q;
    logic accept, more, start, done, abort;
    mem16_byte_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_byte (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start_i    (start),
        .mem_ready_i(rx_mem_ready),
        .strobe_o   (tx_mem_strobe),
        .done_o     (done),
        .abort_o    (abort)
    );
    always_comb begin
        accept  = state_q == IDLE && rx_req_valid;
        more    = done && word_q && lane_q == LANE_LO;
        start   = accept || more;
        state_d = state_q;
        case (state_q)
            STARTUP: state_d = enable_q && boot_cnt_q == BOOT_LAST ? IDLE : STARTUP;
            IDLE:    state_d = rx_req_valid ? ISSUE : IDLE;
            ISSUE:   state_d = abort || (done && !more) ? RESP : ISSUE;
            RESP:    state_d = rx_resp_ready ? IDLE : RESP;
            default: state_d = STARTUP;
        endcase
    end
    assign tx_req_ready  = state_q == IDLE;
    assign tx_resp_valid = state_q == RESP;
    assign tx_resp_rdata = tx_resp_valid ? rdata_q : '0;
    assign tx_resp_error = tx_resp_valid && error_q;
    assign tx_mem_enable = enable_q;
    assign tx_mem_write  = write_q;
    // 16-bit add wraps 0xFFFF+1 to 0x0000 for the high byte
    assign tx_mem_addr   = addr_q + 16'(lane_q);
    assign tx_mem_data   = lane_q == LANE_HI ? wdata_q[15:8] : wdata_q[7:0];
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= STARTUP;
            lane_q     <= LANE_LO;
            boot_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            word_q     <= 1'b0;
            error_q    <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= 1'b1;
            if (state_q == STARTUP && enable_q) boot_cnt_q <= boot_cnt_q + 1'b1;
            if (accept) begin
                addr_q  <= rx_req_addr;
                wdata_q <= rx_req_wdata;
                write_q <= rx_req_write;
                word_q  <= rx_req_word;
                lane_q  <= LANE_LO;
                rdata_q <= '0;
                error_q <= 1'b0;
            end
            if (done && !write_q && lane_q == LANE_HI) rdata_q[15:8] <= rx_mem_data;
            if (done && !write_q && lane_q == LANE_LO) rdata_q[7:0] <= rx_mem_data;
            if (more) lane_q <= LANE_HI;
            if (abort) begin
                error_q <= 1'b1;
                rdata_q <= '0;
            end
        end
    end
endmodule

// File: doc/mem16_word_port.md
MEM16_WORD_PORT -- requirements
Module: mem16_word_port

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the max cycles waited for memory ready per byte access.
REQ-002 Parameter STARTUP_CYCLES, default 2, SHALL set the post-reset cycles before the first request is accepted.
REQ-003 aclk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 aresetn  in  1  reset SHALL be asynchronous and active-low.
REQ-005 rx_req_valid  in  1  request offered.
REQ-006 tx_req_ready  out  1  request accepted when high with rx_req_valid.
REQ-007 rx_req_write  in  1  1 = write, 0 = read.
REQ-008 rx_req_word  in  1  1 = 16-bit access, 0 = 8-bit access.
REQ-009 rx_req_addr  in  16  byte address.
REQ-010 rx_req_wdata  in  16  write data; byte mode uses [7:0] only.
REQ-011 tx_resp_valid  out  1  response available.
REQ-012 rx_resp_ready  in  1  response consumed when high with tx_resp_valid.
REQ-013 tx_resp_rdata  out  16  read data; byte reads zero-extend; 0 for writes.
REQ-014 tx_resp_error  out  1  access timed out.
REQ-015 tx_mem_enable, tx_mem_write, tx_mem_strobe  out  1 each  drive the downstream 8-bit memory enable, write and strobe inputs.
REQ-016 tx_mem_addr  out  16; tx_mem_data  out  8; rx_mem_data  in  8; rx_mem_ready  in  1  memory address, write byte, read byte, ready.

Function
REQ-017 Little-endian: low byte at addr, high byte at addr+1, which SHALL wrap from 0xFFFF to 0x0000.
REQ-018 States SHALL be STARTUP, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-019 STARTUP SHALL count STARTUP_CYCLES with tx_mem_enable=1, then go to IDLE.
REQ-020 tx_req_ready SHALL be 1 only in IDLE; on accept, addr/wdata/write/word SHALL be latched and state SHALL go to ISSUE for the low byte.
REQ-021 ISSUE SHALL assert tx_mem_strobe for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL wait for rx_mem_ready=0, then go to WAIT_DONE.
REQ-023 WAIT_DONE SHALL wait for rx_mem_ready=1 and, for reads, capture rx_mem_data into the current byte lane in that cycle.
REQ-024 After the low byte: word access SHALL go to ISSUE for the high byte, otherwise to RESP; after the high byte SHALL go to RESP.
REQ-025 tx_mem_addr, tx_mem_write and tx_mem_data SHALL be stable from ISSUE through the WAIT_DONE exit cycle.
REQ-026 Byte latency SHALL be: accept in cycle 0, strobe in cycle 1, tx_resp_valid from cycle 6.
REQ-027 Word latency SHALL be: accept in cycle 0, tx_resp_valid from cycle 11, given a memory 3-state busy window.
REQ-028 RESP SHALL hold valid/rdata/error stable until rx_resp_ready=1, then go to IDLE; there is no new accept in the same cycle.
REQ-029 In either WAIT state, a wait of TIMEOUT_CYCLES SHALL abort to RESP with tx_resp_error=1 and rdata=0, skipping any remaining byte.
REQ-030 rx_req_valid SHALL be ignored outside IDLE.

Reset
REQ-031 On aresetn low, state SHALL be STARTUP and all outputs SHALL be 0, including tx_mem_enable, tx_mem_strobe and tx_resp_valid.
REQ-032 Reset mid-access SHALL abandon the access with no response; the memory-side access is not completed.

Structure
REQ-033 Package mem16_pkg SHALL hold the state enum, byte-lane select type, and default STARTUP_CYCLES/TIMEOUT_CYCLES constants.
REQ-034 Sub-module mem16_byte_port SHALL implement ISSUE/WAIT_BUSY/WAIT_DONE plus the timeout counter for one byte.
REQ-035 mem16_word_port SHALL sequence that sub-module once or twice.

Verification
REQ-036 Word write 0xBEEF to 0x1234, then word read 0x1234 -> rdata 0xBEEF; memory bytes are 0x1234=0xEF and 0x1235=0xBE.
REQ-037 Byte read 0x1235 after REQ-036 -> rdata 0x00BE, valid 6 cycles after accept.
REQ-038 Word write 0xA55A to 0xFFFF -> bytes 0xFFFF=0x5A and 0x0000=0xA5; a word read returns 0xA55A.
REQ-039 Memory model holding ready=1 after strobe -> error=1, rdata=0 after TIMEOUT_CYCLES; the next request then succeeds.
REQ-040 rx_resp_ready held low for 5 cycles -> response stable and tx_req_ready=0 throughout; a reset pulse mid-word-read -> STARTUP with all outputs 0.
